manchester_frame_scheduler: RTL and testbench
=============================================

MANCHESTER_FRAME_SCHEDULER -- requirements
Module: manchester_frame_scheduler

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- NUM_REQ, 4, number of requester channels (2..8).
- PREAMBLE, 8'h55, first framing byte.
- SFD, 8'hD5, second framing byte.
- GAP_CYCLES, 2, idle cycles enforced between frames (1..15).
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, reset; synchronous, active-low.
- req_valid, in, NUM_REQ, per-channel byte valid.
- req_data, in, 8*NUM_REQ, per-channel byte; channel i occupies bits [8i+7:8i].
- req_last, in, NUM_REQ, marks the final payload byte of a frame.
- req_ready, out, NUM_REQ, per-channel byte accept.
- tx_valid, out, 1, byte valid toward the Manchester serializer.
- tx_data, out, 8, byte toward the serializer.
- tx_ready, in, 1, serializer can take a byte.
- grant_id, out, clog2(NUM_REQ), channel that owns the current frame.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 A byte SHALL transfer on the tx side only in a cycle where tx_valid=1 and tx_ready=1. On channel g it SHALL transfer only where req_valid[g]=1 and req_ready[g]=1.
REQ-004 The FSM SHALL have the states IDLE, PRE, SFD, PAY, CRC and GAP.
REQ-005 From IDLE with any req_valid=1, the block SHALL grant by round-robin, searching upward from (last_grant+1) mod NUM_REQ, register grant_id, and enter PRE on the next cycle.
REQ-006 In PRE, tx_valid SHALL be 1 and tx_data SHALL be PREAMBLE. On transfer the FSM SHALL go to SFD.
REQ-007 In SFD, tx_valid SHALL be 1 and tx_data SHALL be SFD. On transfer the FSM SHALL go to PAY.
REQ-008 In PAY, the tx side SHALL pass channel g straight through:
- tx_valid = req_valid[g]; tx_data = req_data[g]; req_ready[g] = tx_ready.
- All other req_ready bits SHALL be 0.
REQ-009 A PAY transfer with req_last[g]=1 SHALL move the FSM to CRC if CRC is compiled in, else to GAP.
REQ-010 If req_valid[g] drops mid-frame, the FSM SHALL stay in PAY with tx_valid=0. The grant SHALL NOT change until the last byte transfers.
REQ-011 Once tx_valid=1 in PRE, SFD or CRC, tx_valid and tx_data SHALL hold stable until the transfer.
REQ-012 GAP SHALL last exactly GAP_CYCLES cycles with tx_valid=0 and req_ready=0, then return to IDLE.
REQ-013 last_grant SHALL update only on entry to PRE.
REQ-014 In IDLE, PRE, SFD, CRC and GAP, every req_ready bit SHALL be 0.
REQ-015 Requests that arrive while busy=1 SHALL only be evaluated on return to IDLE.
REQ-016 A single-byte frame (req_last=1 on the first PAY byte) SHALL be legal.

Reset
REQ-017 While rst=0 at a rising edge, the block SHALL enter IDLE and set:
- tx_valid=0, tx_data=8'h00, req_ready=0, busy=0, grant_id=0.
- last_grant=NUM_REQ-1, so the first grant searches from channel 0.
- gap counter=0, crc register=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately, with no CRC or gap emitted.

Configuration
REQ-019 When macro MANCHESTER_SCHED_CRC_EN is defined, the block SHALL include the CRC state:
- CRC-8, polynomial 0x07, init 0x00, MSB-first, computed over payload bytes only.
- The CRC is cleared on entry to PRE and updated on every PAY transfer.
- In CRC, tx_valid=1 and tx_data is the CRC value; on transfer the FSM goes to GAP.
REQ-020 When MANCHESTER_SCHED_CRC_EN is not defined, the CRC state and CRC register SHALL be absent and PAY SHALL go directly to GAP.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single frame: ch1 sends 0x01 with last=1, tx_ready=1 constant -> tx bytes 55, D5, 01 (plus 07 with CRC_EN); grant_id=1; then 2 idle cycles.
- Round-robin: ch0 and ch2 both valid constantly, one-byte frames -> grant order 0, 2, 0, 2; no channel starved.
- Backpressure: tx_ready=0 for 5 cycles during SFD -> tx_data stays D5 and tx_valid stays 1; no req_ready pulse.
- Requester stall: ch3 drops req_valid for 3 cycles mid-payload -> tx_valid=0 for those cycles, grant_id stays 3, byte order preserved.
- Reset mid-frame: rst=0 during PAY -> next cycle busy=0, tx_valid=0, req_ready=0; next grant searches from channel 0.
- CRC check (CRC_EN): payload 0x31..0x39 ("123456789") -> CRC byte 0xF4.

Source files
------------

// File: rtl/manchester_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | manchester_frame_scheduler                                                 |
// | Round-robin framer: PREAMBLE, SFD, payload pass-through, optional CRC-8,   |
// | then an enforced idle gap. CRC state built only with MANCHESTER_SCHED_CRC_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module manchester_frame_scheduler #(
  parameter int          NUM_REQ    = 4,
  parameter logic [7:0]  PREAMBLE   = 8'h55,
  parameter logic [7:0]  SFD        = 8'hD5,
  parameter int          GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int                c_GW        = $clog2(NUM_REQ);
  localparam logic [c_GW-1:0]   c_LAST_INIT = c_GW'(NUM_REQ - 1);
  localparam logic [3:0]        c_GAP_LOAD  = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_PAY  = 3'd3,
    S_GAP  = 3'd4
`ifdef MANCHESTER_SCHED_CRC_EN
    , S_CRC = 3'd5
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_GW-1:0]   r_grant;
  logic [c_GW-1:0]   r_last_grant;
  logic [3:0]        r_gap_cnt;

  logic              w_found;
  logic [c_GW-1:0]   w_pick;
  logic [c_GW-1:0]   w_rr_idx;
  logic [NUM_REQ-1:0] w_sel;
  logic [7:0]        w_data_arr [NUM_REQ];
  logic [7:0]        w_gdata;
  logic              w_gvalid;
  logic              w_glast;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    assign w_data_arr[i] = req_data[8*i +: 8];
    assign w_sel[i]      = (int'(r_grant) == i);
  end

  assign w_gdata  = w_data_arr[r_grant];
  assign w_gvalid = req_valid[r_grant];
  assign w_glast  = req_last[r_grant];

  // Search upward starting one past the previous owner, wrapping at NUM_REQ.
  always_comb begin : p_rr
    int s;
    w_found  = 1'b0;
    w_pick   = '0;
    w_rr_idx = '0;
    s        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = int'(r_last_grant) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      w_rr_idx = s[c_GW-1:0];
      if (!w_found && req_valid[w_rr_idx]) begin
        w_found = 1'b1;
        w_pick  = w_rr_idx;
      end
    end
  end

`ifdef MANCHESTER_SCHED_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_comb begin : p_fsm
    w_next    = r_state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_PRE;
      end
      S_PRE: begin
        tx_valid = 1'b1;
        tx_data  = PREAMBLE;
        if (tx_ready) w_next = S_SFD;
      end
      S_SFD: begin
        tx_valid = 1'b1;
        tx_data  = SFD;
        if (tx_ready) w_next = S_PAY;
      end
      S_PAY: begin
        tx_valid  = w_gvalid;
        tx_data   = w_gdata;
        req_ready = w_sel & {NUM_REQ{tx_ready}};
        if (w_gvalid && tx_ready && w_glast) begin
`ifdef MANCHESTER_SCHED_CRC_EN
          w_next = S_CRC;
`else
          w_next = S_GAP;
`endif
        end
      end
`ifdef MANCHESTER_SCHED_CRC_EN
      S_CRC: begin
        tx_valid = 1'b1;
        tx_data  = r_crc;
        if (tx_ready) w_next = S_GAP;
      end
`endif
      S_GAP: begin
        if (r_gap_cnt == 4'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : p_seq
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= c_LAST_INIT;
      r_gap_cnt    <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
      // Counter is loaded on GAP entry so the state lasts exactly GAP_CYCLES.
      if (w_next == S_GAP && r_state != S_GAP) begin
        r_gap_cnt <= c_GAP_LOAD;
      end else if (r_state == S_GAP && r_gap_cnt != 4'd0) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end
    end
  end

`ifdef MANCHESTER_SCHED_CRC_EN
  always_ff @(posedge clk) begin : p_crc
    if (!rst) begin
      r_crc <= 8'h00;
    end else if (r_state == S_IDLE && w_found) begin
      r_crc <= 8'h00;
    end else if (r_state == S_PAY && w_gvalid && tx_ready) begin
      r_crc <= f_crc8(r_crc, w_gdata);
    end
  end
`endif

  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_manchester_frame_scheduler.sv
`default_nettype none
// Bench for manchester_frame_scheduler: directed scenarios plus random frames
// compared against a frame-level round-robin model.
module tb_manchester_frame_scheduler;

  localparam int         N     = 4;
  localparam int         GW    = $clog2(N);
  localparam int         GAP   = 2;
  localparam logic [7:0] PRE_B = 8'h55;
  localparam logic [7:0] SFD_B = 8'hD5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [GW-1:0]   grant_id;
  logic            busy;

  manchester_frame_scheduler #(
    .NUM_REQ(N), .PREAMBLE(PRE_B), .SFD(SFD_B), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0]      chq [N][$];   // {last,data} still to be offered by each requester
  logic [8:0]      mq  [N][$];   // same frames, consumed by the reference model
  logic [GW+7:0]   obs_q[$];     // {grant,data} seen on tx
  logic [GW+7:0]   exp_q[$];
  logic [N-1:0]    stall;
  int              acc_cnt [N];
  int              model_lg;
  int              cyc;
  int              last_xfer_cyc;
  logic            s_tx_valid;
  logic [7:0]      s_tx_data;
  logic [GW-1:0]   s_grant;
  logic [N-1:0]    s_req_ready;
  logic            s_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef MANCHESTER_SCHED_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  function automatic bit any_pending();
    for (int c = 0; c < N; c++) if (chq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_frame(input int ch, input int len, input logic [7:0] base, input bit rnd);
    logic [8:0] b;
    for (int i = 0; i < len; i++) begin
      b[7:0] = rnd ? 8'($urandom) : base + 8'(i);
      b[8]   = (i == len - 1);
      chq[ch].push_back(b);
      mq[ch].push_back(b);
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < N; c++) begin
      chq[c].delete();
      mq[c].delete();
      acc_cnt[c] = 0;
    end
    stall = '0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (chq[c].size() > 0 && !stall[c]) begin
        req_valid[c]       = 1'b1;
        req_data[8*c +: 8] = chq[c][0][7:0];
        req_last[c]        = chq[c][0][8];
      end else begin
        req_valid[c]       = 1'b0;
        req_data[8*c +: 8] = 8'($urandom);
        req_last[c]        = 1'($urandom);
      end
    end
  endtask

  // One clock: drive at the falling edge, observe mid-low-phase, account transfers.
  task automatic cycle();
    drive();
    #2;
    s_tx_valid  = tx_valid;
    s_tx_data   = tx_data;
    s_grant     = grant_id;
    s_req_ready = req_ready;
    s_busy      = busy;
    if (rst) begin
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      if (!busy) chk("ready_idle", 32'(req_ready), 0);
      for (int c = 0; c < N; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          chk("pass_fire", 32'(tx_valid && tx_ready), 1);
          chk("pass_data", 32'(tx_data), 32'(chq[c][0][7:0]));
          chk("pass_grant", 32'(grant_id), c);
          if (chq[c][0][8]) acc_cnt[c] = 0;
          else acc_cnt[c]++;
          void'(chq[c].pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        obs_q.push_back({grant_id, tx_data});
        last_xfer_cyc = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((any_pending() || busy) && k < 3000) begin
      cycle();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 3000), 1);
  endtask

  // Every queued frame is visible at each arbitration, so the frame order is a
  // plain round-robin walk over the channels that still have frames.
  task automatic build_expected();
    int         c;
    int         t;
    logic [8:0] b;
`ifdef MANCHESTER_SCHED_CRC_EN
    logic [7:0] crc;
`endif
    while (1) begin
      c = -1;
      for (int k = 1; k <= N; k++) begin
        t = (model_lg + k) % N;
        if (c < 0 && mq[t].size() > 0) c = t;
      end
      if (c < 0) break;
      model_lg = c;
      exp_q.push_back({c[GW-1:0], PRE_B});
      exp_q.push_back({c[GW-1:0], SFD_B});
`ifdef MANCHESTER_SCHED_CRC_EN
      crc = 8'h00;
`endif
      do begin
        b = mq[c].pop_front();
        exp_q.push_back({c[GW-1:0], b[7:0]});
`ifdef MANCHESTER_SCHED_CRC_EN
        crc = crc8(crc, b[7:0]);
`endif
      end while (!b[8]);
`ifdef MANCHESTER_SCHED_CRC_EN
      exp_q.push_back({c[GW-1:0], crc});
`endif
    end
  endtask

  task automatic compare(input string tag);
    build_expected();
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_all();
    cycle();
    cycle();
    rst = 1'b1;
    model_lg = N - 1;
  endtask

  initial begin
    int k;
    rst = 1'b0; tx_ready = 1'b1; stall = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    cyc = 0; last_xfer_cyc = 0; model_lg = N - 1;
    clear_all();
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);

    // Single one-byte frame on ch1 and exact gap length
    add_frame(1, 1, 8'h01, 1'b0);
    drain("single");
    chk("single_gap", cyc - last_xfer_cyc, GAP + 1);
    compare("single");

    // Round-robin between ch0 and ch2 from reset: 0,2,0,2
    do_reset();
    add_frame(0, 1, 8'hA0, 1'b0); add_frame(0, 1, 8'hA1, 1'b0);
    add_frame(2, 1, 8'hB0, 1'b0); add_frame(2, 1, 8'hB1, 1'b0);
    drain("rr");
    compare("rr");

    // Backpressure during SFD
    add_frame(0, 2, 8'hC0, 1'b0);
    k = 0;
    while (obs_q.size() == 0 && k < 50) begin cycle(); k++; end
    chk("bp_timeout", 32'(k < 50), 1);
    tx_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_valid", 32'(s_tx_valid), 1);
      chk("bp_data", 32'(s_tx_data), 32'(SFD_B));
      chk("bp_ready", 32'(s_req_ready), 0);
    end
    tx_ready = 1'b1;
    drain("bp");
    compare("bp");

    // Requester stall mid-payload on ch3
    add_frame(3, 5, 8'h10, 1'b0);
    k = 0;
    while (acc_cnt[3] < 2 && k < 50) begin cycle(); k++; end
    chk("stall_timeout", 32'(k < 50), 1);
    stall[3] = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_valid", 32'(s_tx_valid), 0);
      chk("stall_grant", 32'(s_grant), 3);
      chk("stall_busy", 32'(s_busy), 1);
    end
    stall = '0;
    drain("stall");
    compare("stall");

    // Reset in the middle of a payload on ch2
    add_frame(2, 6, 8'h60, 1'b0);
    k = 0;
    while (acc_cnt[2] < 1 && k < 50) begin cycle(); k++; end
    chk("abort_timeout", 32'(k < 50), 1);
    rst = 1'b0;
    clear_all();
    cycle();
    rst = 1'b1;
    model_lg = N - 1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_tx_valid", 32'(tx_valid), 0);
    chk("abort_req_ready", 32'(req_ready), 0);
    add_frame(1, 1, 8'h71, 1'b0);
    add_frame(3, 1, 8'h73, 1'b0);
    drain("abort");
    compare("abort");

`ifdef MANCHESTER_SCHED_CRC_EN
    // CRC-8 check value of "123456789"
    add_frame(0, 9, 8'h31, 1'b0);
    drain("crc");
    chk("crc_byte", 32'(obs_q[obs_q.size()-1][7:0]), 32'h F4);
    compare("crc");
`endif

    // Random frames, random tx_ready and requester stalls
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < N; c++) begin
        k = $urandom_range(0, 2);
        for (int f = 0; f < k; f++) add_frame(c, $urandom_range(1, 6), 8'h00, 1'b1);
      end
      k = 0;
      while ((any_pending() || busy) && k < 3000) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < N; c++) stall[c] = (acc_cnt[c] > 0) && ($urandom_range(0, 3) == 0);
        cycle();
        k++;
      end
      stall = '0;
      tx_ready = 1'b1;
      chk("rand_timeout", 32'(k < 3000), 1);
      compare("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
